timebase_taps: RTL and testbench



---
 rtl/timebase_pkg.sv | 13 +
 rtl/timebase_taps.sv | 60 ++++++
 tb/tb_timebase_taps.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/timebase_pkg.sv
// Shared timebase definitions: default widths and the tap-to-counter-bit mapping
// used by both the prescaler and any consumer doing divider/rate math.
package timebase_pkg;

  localparam int TB_WIDTH = 32;
  localparam int TB_NTAPS = 6;

  // Taps are spread evenly from bit 0 up to the counter MSB.
  function automatic int tap_bit(input int i, input int width, input int ntaps);
    return (i * (width - 1)) / (ntaps - 1);
  endfunction

endpackage

// File: rtl/timebase_taps.sv
// Free-running prescaler: WIDTH-bit counter with one-cycle strobes on the rising
// edge of selected counter bits, plus a wrap strobe on all-ones -> zero.
module timebase_taps
  import timebase_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int NTAPS = TB_NTAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  output logic [NTAPS-1:0] taps,
  output logic             wrap,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d, countInc;
  logic [NTAPS-1:0] taps_q, taps_d, tapRise;
  logic             wrap_q, wrap_d;

  assign countInc = count_q + WIDTH'(1);

  // A tap bit rises exactly when the increment carries into it, so strobes
  // line up with the cycle in which count already shows the new value.
  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    localparam int TapBit = tap_bit(i, WIDTH, NTAPS);
    assign tapRise[i] = countInc[TapBit] & ~count_q[TapBit];
  end

  always_comb begin
    count_d = count_q;
    taps_d  = '0;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = countInc;
      taps_d  = tapRise;
      wrap_d  = &count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      taps_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      taps_q  <= taps_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign taps  = taps_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_timebase_taps.sv
// Bench for timebase_taps: an 8-bit/4-tap and a 32-bit/6-tap instance share stimulus
// and are checked every edge against an arithmetic model of counter and strobes.
module tb_timebase_taps;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] taps8;
  logic       wrap8;
  logic [7:0] count8;
  logic [5:0] taps32;
  logic       wrap32;
  logic [31:0] count32;

  int nVec = 0;
  int nMiss = 0;

  int bits8[4]  = '{0, 2, 4, 7};
  int bits32[6] = '{0, 6, 12, 18, 24, 31};

  longint unsigned mc8, mc32;
  logic [3:0] expT8;
  logic [5:0] expT32;
  logic       expW8, expW32;

  timebase_taps #(.WIDTH(8), .NTAPS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
    .taps(taps8), .wrap(wrap8), .count(count8)
  );

  timebase_taps #(.WIDTH(32), .NTAPS(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
    .taps(taps32), .wrap(wrap32), .count(count32)
  );

  always #5 clk = ~clk;

  // A bit b rises on n exactly when n mod 2^(b+1) equals 2^b.
  function automatic logic rises(longint unsigned n, int b);
    longint unsigned period = 64'd1 << (b + 1);
    return (n % period) == (64'd1 << b);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMiss++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("count8", 64'(count8), 64'(mc8));
    checkOutput("taps8", 64'(taps8), 64'(expT8));
    checkOutput("wrap8", 64'(wrap8), 64'(expW8));
    checkOutput("count32", 64'(count32), 64'(mc32));
    checkOutput("taps32", 64'(taps32), 64'(expT32));
    checkOutput("wrap32", 64'(wrap32), 64'(expW32));
  endtask

  task automatic modelReset();
    mc8 = 0; mc32 = 0; expT8 = '0; expT32 = '0; expW8 = 1'b0; expW32 = 1'b0;
  endtask

  // Drive one edge's worth of inputs, advance the model, check both instances.
  task automatic applyStimulus(input logic r, input logic c);
    run = r;
    clear = c;
    @(posedge clk);
    #1;
    expT8 = '0; expT32 = '0; expW8 = 1'b0; expW32 = 1'b0;
    if (c) begin
      mc8 = 0;
      mc32 = 0;
    end else if (r) begin
      mc8 = (mc8 + 1) % 256;
      mc32 = (mc32 + 1) % (64'd1 << 32);
      for (int i = 0; i < 4; i++) expT8[i] = rises(mc8, bits8[i]);
      for (int i = 0; i < 6; i++) expT32[i] = rises(mc32, bits32[i]);
      expW8 = (mc8 == 0);
      expW32 = (mc32 == 0);
    end
    checkAll();
  endtask

  initial begin
    int pulses2, pulses3, wraps, edgeNo, lastHit, period;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0);

    pulses2 = 0; pulses3 = 0; wraps = 0;
    for (int k = 0; k < 246; k++) begin
      applyStimulus(1'b1, 1'b0);
      pulses2 += int'(taps8[2]);
      pulses3 += int'(taps8[3]);
      wraps   += int'(wrap8);
    end
    checkOutput("tap2Pulses", 64'(pulses2), 64'd8);
    checkOutput("tap3Pulses", 64'(pulses3), 64'd1);
    checkOutput("wrapPulses", 64'(wraps), 64'd1);

    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    while (mc8 != 127) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    while (mc8 != 201) applyStimulus(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);

    edgeNo = 0; lastHit = -1; period = -1;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, 1'b0);
      edgeNo++;
      if (taps32[1]) begin
        if (lastHit >= 0) period = edgeNo - lastHit;
        lastHit = edgeNo;
      end
    end
    checkOutput("tap1Period32", 64'(period), 64'd128);

    for (int k = 0; k < 600; k++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
